// File: rtl/clock_phase_gen.sv
// Phase-aligned clock generator: NUM_CH channels divided by 2^sel from one shared counter.
// Optional per-channel gating is enabled with the CLOCK_PHASE_GEN_GATE_EN macro.
module clock_phase_gen #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 4,
   parameter int SEL_W  = 3,
   parameter logic [NUM_CH*SEL_W-1:0] RESET_SEL = {3'd2, 3'd1, 3'd2, 3'd0},
   parameter logic [NUM_CH-1:0]       RESET_INV = 4'b0101,
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clock,
   input  logic              reset,
`ifdef CLOCK_PHASE_GEN_GATE_EN
   input  logic [NUM_CH-1:0] gate_en,
`endif
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [SEL_W-1:0]  cfg_sel,
   input  logic              cfg_inv,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick,
   output logic              wrap,
   output logic [CNT_W-1:0]  cnt
);

   logic [CNT_W-1:0]              r_cnt;
   logic [NUM_CH-1:0][SEL_W-1:0]  r_sel;
   logic [NUM_CH-1:0]             r_inv;
   logic [NUM_CH-1:0]             r_clk;
   logic                          r_pending;
   logic                          r_ready;
   logic [CH_W-1:0]               r_pCh;
   logic [SEL_W-1:0]              r_pSel;
   logic                          r_pInv;

   logic [CNT_W-1:0]              w_nextCnt;
   logic [NUM_CH-1:0][SEL_W-1:0]  w_nextSel;
   logic [NUM_CH-1:0]             w_nextInv;
   logic [NUM_CH-1:0]             w_clkNext;
   logic [NUM_CH-1:0]             w_gateCur;
   logic [NUM_CH-1:0]             w_gateNext;
   logic [SEL_W-1:0]              w_cfgSelClamp;
   logic                          w_wrap;
   logic                          w_apply;

   assign w_wrap        = &r_cnt;
   assign w_apply       = r_pending & w_wrap;
   assign w_nextCnt     = r_cnt + CNT_W'(1);
   assign w_cfgSelClamp = (cfg_sel > SEL_W'(CNT_W)) ? SEL_W'(CNT_W) : cfg_sel;

`ifdef CLOCK_PHASE_GEN_GATE_EN
   logic [NUM_CH-1:0] r_gate;

   // Gate state only changes at the common wrap, so no phase is ever cut short.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         r_gate <= '1;
      else if (w_wrap)
         r_gate <= gate_en;
   end

   assign w_gateCur  = r_gate;
   assign w_gateNext = w_wrap ? gate_en : r_gate;
`else
   assign w_gateCur  = '1;
   assign w_gateNext = '1;
`endif

   // Next-cycle channel settings and registered clock values; out-of-range channels match no slot.
   always_comb begin
      w_nextSel = r_sel;
      w_nextInv = r_inv;
      w_clkNext = '0;
      tick      = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (w_apply && (r_pCh == CH_W'(i))) begin
            w_nextSel[i] = r_pSel;
            w_nextInv[i] = r_pInv;
         end
         w_clkNext[i] = w_nextInv[i];
         for (int k = 1; k <= CNT_W; k++) begin
            if (w_nextSel[i] == SEL_W'(k))
               w_clkNext[i] = w_nextCnt[k-1] ^ w_nextInv[i];
         end
         if (!w_gateNext[i])
            w_clkNext[i] = w_nextInv[i];
         if (r_sel[i] == '0)
            tick[i] = w_gateNext[i] & reset;
         else
            tick[i] = ~r_clk[i] & w_clkNext[i] & reset;
      end
   end

   // Undivided channels bypass the register and follow the source clock directly.
   always_comb begin
      clk_out = r_clk;
      for (int i = 0; i < NUM_CH; i++) begin
         if (r_sel[i] == '0)
            clk_out[i] = w_gateCur[i] ? (clock ^ r_inv[i]) : r_inv[i];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cnt     <= '0;
         r_sel     <= RESET_SEL;
         r_inv     <= RESET_INV;
         r_clk     <= RESET_INV;
         r_pending <= 1'b0;
         r_ready   <= 1'b0;
         r_pCh     <= '0;
         r_pSel    <= '0;
         r_pInv    <= 1'b0;
      end else begin
         r_cnt <= w_nextCnt;
         r_sel <= w_nextSel;
         r_inv <= w_nextInv;
         r_clk <= w_clkNext;
         if (w_apply) begin
            r_pending <= 1'b0;
            r_ready   <= 1'b1;
         end else if (cfg_valid && r_ready) begin
            r_pending <= 1'b1;
            r_ready   <= 1'b0;
            r_pCh     <= cfg_ch;
            r_pSel    <= w_cfgSelClamp;
            r_pInv    <= cfg_inv;
         end else if (!r_pending) begin
            r_ready <= 1'b1;
         end
      end
   end

   assign cfg_ready = r_ready;
   assign wrap      = w_wrap;
   assign cnt       = r_cnt;

endmodule

// File: tb/tb_clock_phase_gen.sv
// Directed bench for clock_phase_gen: default phases, config apply timing, clamping,
// wrap-cycle transfers, out-of-range channels and reset while a request is pending.
module tb_clock_phase_gen;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       cfgValid = 1'b0;
   logic [1:0] cfgCh = '0;
   logic [2:0] cfgSel = '0;
   logic       cfgInv = 1'b0;
   logic       cfgReady;
   logic [3:0] clkOut;
   logic [3:0] tick;
   logic       wrap;
   logic [3:0] cnt;

   logic       bValid = 1'b0;
   logic [1:0] bCh = '0;
   logic [2:0] bSel = '0;
   logic       bInv = 1'b0;
   logic       bReady;
   logic [2:0] bClkOut;
   logic [2:0] bTick;
   logic       bWrap;
   logic [3:0] bCnt;

`ifdef CLOCK_PHASE_GEN_GATE_EN
   logic [3:0] gateEn = '1;
   logic [2:0] bGateEn = '1;
`endif

   int nCompared = 0;
   int nMismatched = 0;

   always #5 clock = ~clock;

   clock_phase_gen dut (
      .clock     (clock),
      .reset     (reset),
`ifdef CLOCK_PHASE_GEN_GATE_EN
      .gate_en   (gateEn),
`endif
      .cfg_valid (cfgValid),
      .cfg_ready (cfgReady),
      .cfg_ch    (cfgCh),
      .cfg_sel   (cfgSel),
      .cfg_inv   (cfgInv),
      .clk_out   (clkOut),
      .tick      (tick),
      .wrap      (wrap),
      .cnt       (cnt)
   );

   // Three-channel instance so a channel index past NUM_CH can actually be driven.
   clock_phase_gen #(
      .NUM_CH    (3),
      .CNT_W     (4),
      .SEL_W     (3),
      .RESET_SEL ({3'd1, 3'd2, 3'd0}),
      .RESET_INV (3'b000)
   ) dut3 (
      .clock     (clock),
      .reset     (reset),
`ifdef CLOCK_PHASE_GEN_GATE_EN
      .gate_en   (bGateEn),
`endif
      .cfg_valid (bValid),
      .cfg_ready (bReady),
      .cfg_ch    (bCh),
      .cfg_sel   (bSel),
      .cfg_inv   (bInv),
      .clk_out   (bClkOut),
      .tick      (bTick),
      .wrap      (bWrap),
      .cnt       (bCnt)
   );

   typedef struct {
      logic       valid;
      logic [1:0] ch;
      logic [2:0] sel;
      logic       inv;
      logic [3:0] expCnt;
      logic [3:0] expClk;
      logic [3:0] expTick;
      logic       expWrap;
      logic       expReady;
   } vector_t;

   vector_t vectors [8];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [1:0] ch, input logic [2:0] sel, input logic inv);
      cfgValid = valid;
      cfgCh    = ch;
      cfgSel   = sel;
      cfgInv   = inv;
      @(posedge clock);
      #1;
   endtask

   task automatic stepCycle();
      applyStimulus(1'b0, 2'd0, 3'd0, 1'b0);
   endtask

   task automatic waitCnt(input logic [3:0] target);
      int guard = 0;
      while (cnt !== target && guard < 40) begin
         stepCycle();
         guard++;
      end
      checkOutput("waitCnt", 32'(cnt), 32'(target));
   endtask

   initial begin
      // Defaults: ch0 sel0 inv1, ch1 sel2 inv0, ch2 sel1 inv1, ch3 sel2 inv0; sampled with clock high.
      vectors[0] = '{1'b0, 2'd0, 3'd0, 1'b0, 4'd1, 4'b0000, 4'b1111, 1'b0, 1'b1};
      vectors[1] = '{1'b0, 2'd0, 3'd0, 1'b0, 4'd2, 4'b1110, 4'b0001, 1'b0, 1'b1};
      vectors[2] = '{1'b0, 2'd0, 3'd0, 1'b0, 4'd3, 4'b1010, 4'b0101, 1'b0, 1'b1};
      vectors[3] = '{1'b0, 2'd0, 3'd0, 1'b0, 4'd4, 4'b0100, 4'b0001, 1'b0, 1'b1};
      vectors[4] = '{1'b0, 2'd0, 3'd0, 1'b0, 4'd5, 4'b0000, 4'b1111, 1'b0, 1'b1};
      vectors[5] = '{1'b0, 2'd0, 3'd0, 1'b0, 4'd6, 4'b1110, 4'b0001, 1'b0, 1'b1};
      vectors[6] = '{1'b0, 2'd0, 3'd0, 1'b0, 4'd7, 4'b1010, 4'b0101, 1'b0, 1'b1};
      vectors[7] = '{1'b0, 2'd0, 3'd0, 1'b0, 4'd8, 4'b0100, 4'b0001, 1'b0, 1'b1};

      #1 reset = 1'b0;
      #1;
      checkOutput("rstCnt", 32'(cnt), 32'd0);
      checkOutput("rstReady", 32'(cfgReady), 32'd0);
      checkOutput("rstTick", 32'(tick), 32'd0);
      checkOutput("rstWrap", 32'(wrap), 32'd0);
      checkOutput("rstClkLow", 32'(clkOut), 32'b0101);
      #5;
      checkOutput("rstClkHigh", 32'(clkOut), 32'b0100);
      #15 reset = 1'b1;

      @(posedge clock);
      #1;
      for (int i = 0; i < 8; i++) begin
         if (i > 0)
            applyStimulus(vectors[i].valid, vectors[i].ch, vectors[i].sel, vectors[i].inv);
         checkOutput($sformatf("vecCnt%0d", i), 32'(cnt), 32'(vectors[i].expCnt));
         checkOutput($sformatf("vecClk%0d", i), 32'(clkOut), 32'(vectors[i].expClk));
         checkOutput($sformatf("vecTick%0d", i), 32'(tick), 32'(vectors[i].expTick));
         checkOutput($sformatf("vecWrap%0d", i), 32'(wrap), 32'(vectors[i].expWrap));
         checkOutput($sformatf("vecReady%0d", i), 32'(cfgReady), 32'(vectors[i].expReady));
      end

      // ch2 -> sel4 inv0 requested at cnt=3; dut3 gets an out-of-range channel at the same time.
      waitCnt(4'd3);
      bValid = 1'b1; bCh = 2'd3; bSel = 3'd1; bInv = 1'b1;
      applyStimulus(1'b1, 2'd2, 3'd4, 1'b0);
      bValid = 1'b0;
      checkOutput("readyLowAfterXfer", 32'(cfgReady), 32'd0);
      checkOutput("bReadyLowAfterXfer", 32'(bReady), 32'd0);
      waitCnt(4'd14);
      checkOutput("ch2OldBeforeApply", 32'(clkOut[2]), 32'd1);
      waitCnt(4'd15);
      checkOutput("readyLowAtWrap", 32'(cfgReady), 32'd0);
      checkOutput("wrapHigh", 32'(wrap), 32'd1);
      stepCycle();
      checkOutput("readyAfterApply", 32'(cfgReady), 32'd1);
      checkOutput("ch2NewAtCnt0", 32'(clkOut[2]), 32'd0);
      checkOutput("bReadyAfterDrop", 32'(bReady), 32'd1);
      stepCycle();
      checkOutput("bClkUnchanged", 32'(bClkOut[2:1]), 32'b10);
      waitCnt(4'd7);
      checkOutput("ch2TickAt7", 32'(tick[2]), 32'd1);
      checkOutput("ch2LowAt7", 32'(clkOut[2]), 32'd0);
      stepCycle();
      checkOutput("ch2HighAt8", 32'(clkOut[2]), 32'd1);
      checkOutput("ch2NoTickAt8", 32'(tick[2]), 32'd0);

      // ch1 -> sel7 (clamped to 4) inv1.
      waitCnt(4'd0);
      applyStimulus(1'b1, 2'd1, 3'd7, 1'b1);
      waitCnt(4'd15);
      checkOutput("ch1OldAtWrap", 32'(clkOut[1]), 32'd1);
      stepCycle();
      checkOutput("ch1ClampCnt0", 32'(clkOut[1]), 32'd1);
      waitCnt(4'd8);
      checkOutput("ch1ClampCnt8", 32'(clkOut[1]), 32'd0);
      waitCnt(4'd15);
      checkOutput("ch1ClampCnt15", 32'(clkOut[1]), 32'd0);
      checkOutput("ch1ClampTick15", 32'(tick[1]), 32'd1);
      checkOutput("readyBeforeWrapXfer", 32'(cfgReady), 32'd1);

      // Transfer in the wrap cycle: ch3 -> sel1 inv1 must wait a full 16 cycles.
      applyStimulus(1'b1, 2'd3, 3'd1, 1'b1);
      checkOutput("wrapXferReadyLow", 32'(cfgReady), 32'd0);
      checkOutput("ch3NotAppliedYet", 32'(clkOut[3]), 32'd0);
      checkOutput("ch1RoseAtCnt0", 32'(clkOut[1]), 32'd1);
      waitCnt(4'd15);
      checkOutput("wrapXferHeld", 32'(cfgReady), 32'd0);
      stepCycle();
      checkOutput("wrapXferReady", 32'(cfgReady), 32'd1);
      checkOutput("ch3AppliedCnt0", 32'(clkOut[3]), 32'd1);
      stepCycle();
      checkOutput("ch3Cnt1", 32'(clkOut[3]), 32'd0);
      checkOutput("ch3TickCnt1", 32'(tick[3]), 32'd1);

      // Reset while ch1 -> sel3 inv0 is pending.
      applyStimulus(1'b1, 2'd1, 3'd3, 1'b0);
      checkOutput("pendReadyLow", 32'(cfgReady), 32'd0);
      waitCnt(4'd5);
      #2 reset = 1'b0;
      #1;
      checkOutput("midRstCnt", 32'(cnt), 32'd0);
      checkOutput("midRstReady", 32'(cfgReady), 32'd0);
      checkOutput("midRstTick", 32'(tick), 32'd0);
      checkOutput("midRstWrap", 32'(wrap), 32'd0);
      checkOutput("midRstClk", 32'(clkOut), 32'b0100);
      @(negedge clock);
      #2 reset = 1'b1;
      @(posedge clock);
      #1;
      checkOutput("postRstCnt", 32'(cnt), 32'd1);
      checkOutput("postRstReady", 32'(cfgReady), 32'd1);
      waitCnt(4'd15);
      stepCycle();
      waitCnt(4'd2);
      checkOutput("pendingLostClk", 32'(clkOut), 32'b1110);
      checkOutput("pendingLostTick", 32'(tick), 32'b0001);
      checkOutput("pendingLostReady", 32'(cfgReady), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] simulation did not complete");
   end

endmodule
